tick_timer: RTL and testbench
=============================

# tick_timer

Programmable down-counting event timer that sits directly downstream of `counter_mod_k_ro`. It consumes that block's `o_roll_over` strobe as a prescaled tick and counts a loaded number of ticks. When the count runs out it emits a single-cycle expiry pulse. It supports one-shot and periodic (auto-reload) modes with start/stop control.

## Interface
- `W`, default 8: width of the tick count, the reload register and `o_count`.
- `i_clk`  in  1: system clock; all state changes on the rising edge.
- `i_reset`  in  1: synchronous, active-low reset (0 = reset, sampled on the rising edge of `i_clk`).
- `i_tick`  in  1: tick strobe, normally `o_roll_over` of `counter_mod_k_ro`; may stay high on consecutive cycles.
- `i_start`  in  1: start/restart request, sampled each cycle.
- `i_stop`  in  1: abort request, sampled each cycle.
- `i_periodic`  in  1: mode select, captured only on an accepted start (1 = auto-reload, 0 = one-shot).
- `i_load`  in  W: tick count, captured on an accepted start.
- `o_busy`  out  1: high while in RUN.
- `o_count`  out  W: remaining ticks in the current period.
- `o_expired`  out  1: one-cycle pulse when a period completes.
- `o_err`  out  1: one-cycle pulse when a start is rejected because `i_load` == 0.

## Operation
- States:
  - IDLE.
  - RUN.
- Registers:
  - `state`.
  - `count[W-1:0]`.
  - `reload[W-1:0]`.
  - `periodic`.
  - `o_expired`.
  - `o_err`.
- Reset (`i_reset` = 0 at an edge):
  - `state` = IDLE; `count` = 0; `reload` = 0; `periodic` = 0.
  - `o_busy` = 0; `o_expired` = 0; `o_err` = 0.
  - Reset overrides every other input, including mid-RUN.
- Priority in each cycle, highest first: reset, then `i_stop`, then `i_start`, then `i_tick`.
- IDLE:
  - `i_start` = 1 and `i_load` != 0: `count` = `reload` = `i_load`; `periodic` = `i_periodic`; next state RUN.
  - `i_start` = 1 and `i_load` == 0: stay in IDLE; `o_err` = 1 for one cycle.
  - `i_tick` and `i_stop` have no effect.
- RUN:
  - `i_stop` = 1: next state IDLE; `count` = 0; no `o_expired` pulse, even if `i_tick` = 1 in the same cycle.
  - `i_start` = 1 with `i_load` != 0: restart. `count` = `reload` = `i_load`; `periodic` recaptured; the same-cycle tick is discarded.
  - `i_start` = 1 with `i_load` == 0: `o_err` pulses and the timer is stopped (next state IDLE, `count` = 0).
  - `i_tick` = 1 and `count` > 1: `count` decrements by 1.
  - `i_tick` = 1 and `count` == 1: `o_expired` = 1 next cycle.
    - If `periodic`: `count` = `reload`, stay in RUN.
    - If not `periodic`: `count` = 0, next state IDLE.
- Arithmetic:
  - Unsigned, modulo 2^W.
  - `count` never underflows: 0 is reachable only in IDLE.
  - A load of 2^W-1 is legal.
- `o_busy` = (`state` == RUN), decoded from registered state, no combinational path from inputs.
- `o_count` = `count`.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Start latency: an accepted start at edge t gives `o_busy` = 1 and `o_count` = `i_load` from edge t onward.
- Tick latency: a tick sampled at edge t updates `o_count` after edge t.
- Expiry: if the final tick is sampled at edge t, `o_expired` is high for exactly the cycle between t and t+1.
  - One-shot: `o_busy` falls at the same edge t.
- Back-to-back ticks (`i_tick` held high):
  - A load of L expires L cycles after the first sampled tick.
  - Periodic mode gives back-to-back periods with no dead cycle.
- Period: with `counter_mod_k_ro` at modulus k, `o_expired` has a period of exactly L·k clocks in periodic mode.
- Reset released at edge t: the first start can be accepted at edge t+1.

## Test plan
- One-shot, L=3:
  - Stimulus: drive ticks from `counter_mod_k_ro` with k=4; reset low for the first edge; pulse start with load=3.
  - Required: `o_count` goes 3→2→1→0 on successive ticks; a single `o_expired` pulse on the third tick edge; `o_busy` drops at that same edge; no further pulses over 40 clocks.
- Periodic, L=2, k=4:
  - Required: `o_expired` pulses every 8 clocks, five times in a row.
  - Required: `o_count` reloads to 2 with no gap; `o_busy` stays 1 throughout.
- Stop collision:
  - Stimulus: run periodic L=1; assert `i_stop` in the same cycle as a tick.
  - Required: no `o_expired`; `o_busy` = 0 and `o_count` = 0 next cycle.
- Restart mid-run:
  - Stimulus: while `o_count` = 5 of L=7, pulse start with load=2 together with a tick.
  - Required: `o_count` = 2 (tick discarded); expiry after 2 further ticks.
- Zero load:
  - Stimulus: start with load=0 in IDLE, then again in RUN.
  - Required: one-cycle `o_err` each time; IDLE with `o_count` = 0 afterwards; never any `o_expired`.
- Reset mid-operation:
  - Stimulus: drive `i_reset` = 0 for one edge while RUN with `o_count` = 4.
  - Required: all outputs 0 after that edge; ticks ignored until a new start.

Source files
------------

// File: rtl/tick_timer.sv
// tick_timer
// Programmable down-counting event timer. Counts a loaded number of tick
// strobes (typically the roll-over of a mod-k prescaler). When the count
// runs out it emits a one-cycle expiry pulse. In periodic mode it reloads
// automatically; in one-shot mode it returns to IDLE.
//
// Handshake: there is no valid/ready pair. i_start, i_stop and i_tick are
// level-sampled strobes, evaluated on every rising edge of i_clk. When
// several are high in the same cycle, the priority is:
//   reset > i_stop > i_start > i_tick
//
// Ports
//   i_clk        system clock (rising edge)
//   i_reset      synchronous active-low reset
//   i_tick       tick strobe; may be held high on consecutive cycles
//   i_start      start / restart request
//   i_stop       abort request (ignored in IDLE)
//   i_periodic   mode, captured on an accepted start (1 = auto-reload)
//   i_load       tick count, captured on an accepted start (0 is rejected)
//   o_busy       high while in RUN
//   o_count      remaining ticks in the current period
//   o_expired    one-cycle pulse when a period completes
//   o_err        one-cycle pulse when a start with i_load == 0 is rejected
//   o_dbg_state  registered FSM state (0 = IDLE, 1 = RUN) for observation
module tick_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_tick,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_periodic,
  input  logic [W-1:0] i_load,
  output logic         o_busy,
  output logic [W-1:0] o_count,
  output logic         o_expired,
  output logic         o_err,
  output logic         o_dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e       state_q,    state_d;
  logic [W-1:0] count_q,    count_d;
  logic [W-1:0] reload_q,   reload_d;
  logic         periodic_q, periodic_d;
  logic         expired_q,  expired_d;
  logic         err_q,      err_d;

  logic         load_ok;

  assign load_ok = (i_load != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    expired_d  = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (load_ok) begin
            count_d    = i_load;
            reload_d   = i_load;
            periodic_d = i_periodic;
            state_d    = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (i_stop) begin
          // Abort wins over a same-cycle final tick: no expiry pulse.
          state_d = IDLE;
          count_d = '0;
        end else if (i_start) begin
          // Restart discards any same-cycle tick.
          if (load_ok) begin
            count_d    = i_load;
            reload_d   = i_load;
            periodic_d = i_periodic;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
            count_d = '0;
          end
        end else if (i_tick) begin
          // count is never 0 in RUN; <= 1 keeps the decrement from wrapping.
          if (count_q > 1) begin
            count_d = count_q - 1'b1;
          end else begin
            expired_d = 1'b1;
            if (periodic_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign o_busy      = (state_q == RUN);
  assign o_count     = count_q;
  assign o_expired   = expired_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick;
  logic         start;
  logic         stop;
  logic         periodic;
  logic [W-1:0] load;
  logic         busy;
  logic [W-1:0] count;
  logic         expired;
  logic         err;
  logic         dbg_state;

  always #5 clk = ~clk;

  tick_timer #(.W(W)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_tick     (tick),
    .i_start    (start),
    .i_stop     (stop),
    .i_periodic (periodic),
    .i_load     (load),
    .o_busy     (busy),
    .o_count    (count),
    .o_expired  (expired),
    .o_err      (err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One output snapshot {busy, count, expired, err}, packed for comparison.
  task automatic chk_out(input string name, input logic eb, input logic [W-1:0] ec,
                         input logic ee, input logic er);
    n_checks++;
    if (busy === eb && count === ec && expired === ee && err === er && dbg_state === eb)
      n_pass++;
    else
      $display("FAIL %s: got busy=%0d count=%0d expired=%0d err=%0d state=%0d expected busy=%0d count=%0d expired=%0d err=%0d",
               name, busy, count, expired, err, dbg_state, eb, ec, ee, er);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic t, input logic s, input logic p_stop,
                       input logic per, input logic [W-1:0] ld);
    rst_n    = r;
    tick     = t;
    start    = s;
    stop     = p_stop;
    periodic = per;
    load     = ld;
  endtask

  // Advance one edge, then settle past it before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic         r, t, s, sp, per;
    logic [W-1:0] ld;
    logic         eb;
    logic [W-1:0] ec;
    logic         ee, er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic r, input logic t, input logic s,
                              input logic sp, input logic per, input logic [W-1:0] ld,
                              input logic eb, input logic [W-1:0] ec, input logic ee,
                              input logic er);
    vec_t v;
    v.name = n; v.r = r; v.t = t; v.s = s; v.sp = sp; v.per = per; v.ld = ld;
    v.eb = eb; v.ec = ec; v.ee = ee; v.er = er;
    return v;
  endfunction

  // ---------------- prescaler model (mod-k roll-over) ----------------
  int ps_cnt;
  function automatic logic ps_next(input int k);
    logic roll;
    roll   = (ps_cnt == k - 1);
    ps_cnt = roll ? 0 : ps_cnt + 1;
    return roll;
  endfunction

  initial begin
    //            name          rst t s sp per load   busy cnt  exp err
    vecs.push_back(mk("reset",     0, 0,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("idle_tick", 1, 1,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("idle_stop", 1, 0,0,1,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("start3",    1, 0,1,0,0,  8'd3,   1, 8'd3,  0,0));
    vecs.push_back(mk("tick_2",    1, 1,0,0,0,  8'd0,   1, 8'd2,  0,0));
    vecs.push_back(mk("hold_2",    1, 0,0,0,0,  8'd0,   1, 8'd2,  0,0));
    vecs.push_back(mk("tick_1",    1, 1,0,0,0,  8'd0,   1, 8'd1,  0,0));
    vecs.push_back(mk("expire_os", 1, 1,0,0,0,  8'd0,   0, 8'd0,  1,0));
    vecs.push_back(mk("after_os",  1, 1,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("zero_idle", 1, 0,1,0,0,  8'd0,   0, 8'd0,  0,1));
    vecs.push_back(mk("err_clear", 1, 0,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("start255",  1, 0,1,0,1,  8'd255, 1, 8'd255,0,0));
    vecs.push_back(mk("tick_254",  1, 1,0,0,0,  8'd0,   1, 8'd254,0,0));
    vecs.push_back(mk("zero_run",  1, 1,1,0,0,  8'd0,   0, 8'd0,  0,1));
    vecs.push_back(mk("after_zr",  1, 1,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("start1p",   1, 0,1,0,1,  8'd1,   1, 8'd1,  0,0));
    vecs.push_back(mk("per_exp_a", 1, 1,0,0,0,  8'd0,   1, 8'd1,  1,0));
    vecs.push_back(mk("per_exp_b", 1, 1,0,0,0,  8'd0,   1, 8'd1,  1,0));
    vecs.push_back(mk("stop_tick", 1, 1,0,1,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("after_st",  1, 1,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("start7",    1, 0,1,0,0,  8'd7,   1, 8'd7,  0,0));
    vecs.push_back(mk("tick_6",    1, 1,0,0,0,  8'd0,   1, 8'd6,  0,0));
    vecs.push_back(mk("tick_5",    1, 1,0,0,0,  8'd0,   1, 8'd5,  0,0));
    vecs.push_back(mk("restart2",  1, 1,1,0,0,  8'd2,   1, 8'd2,  0,0));
    vecs.push_back(mk("rs_tick_1", 1, 1,0,0,0,  8'd0,   1, 8'd1,  0,0));
    vecs.push_back(mk("rs_expire", 1, 1,0,0,0,  8'd0,   0, 8'd0,  1,0));
    vecs.push_back(mk("start6",    1, 0,1,0,1,  8'd6,   1, 8'd6,  0,0));
    vecs.push_back(mk("tick_5b",   1, 1,0,0,0,  8'd0,   1, 8'd5,  0,0));
    vecs.push_back(mk("tick_4",    1, 1,0,0,0,  8'd0,   1, 8'd4,  0,0));
    vecs.push_back(mk("rst_mid",   0, 1,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("post_rst",  1, 1,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("post_rst2", 1, 1,0,0,0,  8'd0,   0, 8'd0,  0,0));
    vecs.push_back(mk("rst_vs_st", 0, 0,1,0,1,  8'd5,   0, 8'd0,  0,0));
    vecs.push_back(mk("st_at_rel", 1, 0,1,0,0,  8'd9,   1, 8'd9,  0,0));
    vecs.push_back(mk("stop_run",  1, 0,0,1,0,  8'd0,   0, 8'd0,  0,0));

    drive(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].sp, vecs[i].per, vecs[i].ld);
      step();
      chk_out(vecs[i].name, vecs[i].eb, vecs[i].ec, vecs[i].ee, vecs[i].er);
    end

    // ---- one-shot L=3 with k=4 prescaled ticks ----
    begin
      logic [W-1:0] exp_c;
      int           n_exp;
      drive(1, 0, 1, 0, 0, 8'd3);
      step();
      chk_out("os_start", 1, 8'd3, 0, 0);
      start  = 0;
      ps_cnt = 0;
      exp_c  = 3;
      n_exp  = 0;
      for (int c = 0; c < 52; c++) begin
        logic t_now;
        logic exp_e;
        t_now = ps_next(4);
        tick  = t_now;
        exp_e = 1'b0;
        if (t_now && exp_c != 0) begin
          if (exp_c == 1) exp_e = 1'b1;
          exp_c = exp_c - 1'b1;
        end
        step();
        if (expired) n_exp++;
        if (t_now || exp_e) chk_out($sformatf("os_cyc%0d", c), exp_c != 0, exp_c, exp_e, 0);
      end
      chk("os_pulse_count", n_exp, 1);
    end

    // ---- periodic L=2 with k=4: pulse every 8 clocks ----
    begin
      int last_t, n_exp, gaps_bad, busy_bad, cnt_bad;
      drive(1, 0, 1, 0, 1, 8'd2);
      step();
      chk_out("per_start", 1, 8'd2, 0, 0);
      start  = 0;
      ps_cnt = 0;
      last_t = -1; n_exp = 0; gaps_bad = 0; busy_bad = 0; cnt_bad = 0;
      for (int c = 0; c < 41; c++) begin
        tick = ps_next(4);
        step();
        if (!busy) busy_bad++;
        if (count != 8'd1 && count != 8'd2) cnt_bad++;
        if (expired) begin
          if (expired && count != 8'd2) cnt_bad++;
          if (last_t >= 0 && c - last_t != 8) gaps_bad++;
          last_t = c;
          n_exp++;
        end
      end
      chk("per_pulses", n_exp, 5);
      chk("per_spacing_bad", gaps_bad, 0);
      chk("per_busy_drop", busy_bad, 0);
      chk("per_count_bad", cnt_bad, 0);
      drive(1, 0, 0, 1, 0, '0);
      step();
      chk_out("per_stopped", 0, 8'd0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
